scalar_fust_scheduler: RTL and testbench
========================================

// Module: scalar_fust_scheduler
// PURPOSE
//  Scoreboard controller for the scalar functional units (ALU, LD_ST, BRANCH).
//  Accepts one dispatched instruction per cycle and allocates its FU status row.
//  Tracks register result status and wakes waiting operands on writeback.
//  Issues ready rows to their FU and grants one register-file writeback per
//  cycle, blocking writebacks that would create a WAR hazard.
//  Sits between dispatch and the scalar FUs/register file.
// PARAMETERS
//  NUM_SFU  3   scalar FU rows; index = fu_scalar code (ALU=0, LD_ST=1, BRANCH=2)
//  NREGS    32  architectural scalar registers; REG_W from types_pkg
// PORTS
//  CLK         in   1            clock
//  RST         in   1            asynchronous reset, active-high
//  disp_valid  in   1            dispatch request
//  disp_ready  out  1            row free and no WAW; handshake = valid&ready
//  disp_fu     in   FU_S_W       target FU (fu_scalar); code 3 is illegal
//  disp_wen    in   1            instruction writes rd
//  disp_rd     in   REG_W        destination register
//  disp_rs1    in   REG_W        source 1 (x0 always ready)
//  disp_rs2    in   REG_W        source 2 (x0 always ready)
//  issue_valid out  NUM_SFU      row f has both operands ready
//  issue_ready in   NUM_SFU      FU f accepts; FU reads RF in this cycle
//  issue_regs  out  NUM_SFU*3*REG_W  {rd,rs1,rs2} per row
//  wb_valid    in   NUM_SFU      FU f has a result
//  wb_ready    out  NUM_SFU      one-hot grant; RF written this cycle
//  flush       in   1            discard all rows and result status
// BEHAVIOUR
//  Reset: rows IDLE, result status invalid; issue_valid=0, wb_ready=0,
//   issue_regs=0, disp_ready=1 for legal disp_fu.
//  Row FSM: IDLE -dispatch-> WAIT -issue handshake-> EXEC -wb grant-> IDLE.
//  issue_valid[f] = WAIT & rdy1 & rdy2 (combinational).
//   Once high, it stays high until the handshake.
//  At dispatch, for each source s: t_s = rstat[rs_s].tag and
//   rdy_s = !rstat[rs_s].valid | rs_s==0.
//   If disp_wen & rd!=0: rstat[rd] <= {1, disp_fu}.
//  disp_ready = legal fu & row[disp_fu]==IDLE & !(disp_wen & rd!=0 & rstat[rd].valid).
//  WAR check: wb of row f is blocked if any WAIT row j!=f has
//   (rs1_j==rd_f & rdy1_j) or (rs2_j==rd_f & rdy2_j), with rd_f!=0.
//  Grant: the lowest-index unblocked row with wb_valid & EXEC gets it.
//   Only one grant per cycle; losers hold wb_valid.
//  On grant of f (next edge): row f -> IDLE.
//   rstat[rd_f] is cleared if its tag==f.
//   Every row with !rdy_s & t_s==f sets rdy_s.
//  wb_valid for a non-EXEC row is ignored (never granted).
//  Issue and writeback on different rows in one cycle are independent.
//  flush: at the next edge all rows go IDLE and rstat is cleared.
//   It overrides a same-cycle dispatch. wb_ready=0 while flush is high.
//  Reset mid-operation: state drops immediately to reset values.
//   In-flight FU results are the FUs' responsibility to discard.
// CONFIGURATION
//  FUST_BYPASS_EN defined: same-cycle forwarding from the writeback grant:
//   - disp_ready sees row g as free when g is granted this cycle.
//   - Dispatch sources whose producer is being granted capture rdy=1.
//   - WAW checks ignore an rstat entry being cleared this cycle.
//  Undefined: all checks use registered state only; each case stalls or waits
//   one extra cycle.
// STRUCTURE
//  types_pkg gets:
//   - NUM_SFU constant
//   - row_state_t enum {IDLE,WAIT,EXEC}
//   - fust_s_row_t extended with state, rdy1, rdy2
//   - rstat_entry_t {valid, fu_sbits_t tag}
//   - fust_s_t array sized NUM_SFU
//  Sub-module fust_row: one row FSM plus wakeup compare, instanced NUM_SFU times.
//  Top holds rstat, the WAR check and the priority grant.
// TESTING
//  1 Reset then dispatch ALU rd=5 rs1=1 rs2=2: issue_valid=001 next cycle;
//    after issue handshake, wb grant -> row IDLE and rstat[5] invalid.
//  2 ALU writes x3; LD_ST rs1=3 dispatched -> LD_ST waits.
//    ALU wb grant -> LD_ST issue_valid rises the next cycle
//    (same-cycle dispatch with FUST_BYPASS_EN).
//  3 WAW: x7 pending from ALU; BRANCH with wen, rd=7 -> disp_ready=0 until ALU wb.
//  4 WAR: LD_ST waits reading x4 (rs2 ready, rs1 pending). ALU writes x4 and
//    asserts wb_valid -> wb_ready=0 until LD_ST issues.
//  5 wb_valid=111, all EXEC, no WAR -> grants 001, 010, 100 on
//    consecutive cycles.
//  6 flush with 3 busy rows plus a dispatch in the same cycle:
//    all IDLE next cycle, the dispatch is dropped, and disp_fu=3 keeps disp_ready=0.

Source files
------------

// File: rtl/scalar_fust_scheduler_pkg.sv
// Shared types for the scalar FU status table (scoreboard) scheduler.
// Row layout, register result status and FU codes.
package scalar_fust_scheduler_pkg;

  localparam int NUM_SFU = 3;
  localparam int NREGS   = 32;
  localparam int REG_W   = 5;
  localparam int FU_S_W  = 2;

  typedef logic [FU_S_W-1:0] fu_sbits_t;

  typedef enum logic [FU_S_W-1:0] {
    ALU    = 2'd0,
    LD_ST  = 2'd1,
    BRANCH = 2'd2
  } fu_scalar_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2
  } row_state_t;

  typedef struct packed {
    row_state_t       state;
    logic             wen;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    fu_sbits_t        t1;
    fu_sbits_t        t2;
    logic             rdy1;
    logic             rdy2;
  } fust_s_row_t;

  typedef struct packed {
    logic      valid;
    fu_sbits_t tag;
  } rstat_entry_t;

  typedef fust_s_row_t fust_s_t [NUM_SFU];

  function automatic logic fu_legal(fu_sbits_t f);
    return int'(f) < NUM_SFU;
  endfunction

endpackage

// File: rtl/scalar_fust_scheduler_row.sv
// One FU status row: IDLE -> WAIT -> EXEC -> IDLE,
// plus the operand wakeup compare against the writeback tag.
module scalar_fust_scheduler_row
  import scalar_fust_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  fust_s_row_t load_row,
  input  logic        issue_ready,
  input  logic        grant,
  input  logic        wake,
  input  fu_sbits_t   wake_tag,
  output fust_s_row_t row,
  output logic        issue_valid
);

  always_comb begin
    issue_valid = (row.state == WAIT) && row.rdy1 && row.rdy2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
    end else if (flush) begin
      row <= '0;
    end else if (load) begin
      row <= load_row;
    end else begin
      if (wake && !row.rdy1 && row.t1 == wake_tag)
        row.rdy1 <= 1'b1;
      if (wake && !row.rdy2 && row.t2 == wake_tag)
        row.rdy2 <= 1'b1;
      unique case (row.state)
        WAIT: if (issue_ready && issue_valid) row.state <= EXEC;
        EXEC: if (grant) row.state <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/scalar_fust_scheduler.sv
// Scalar FU scoreboard: register result status, WAR-guarded writeback grant.
// FUST_BYPASS_EN: forward the writeback grant into same-cycle dispatch.
module scalar_fust_scheduler
  import scalar_fust_scheduler_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [FU_S_W-1:0]            disp_fu,
  input  logic                         disp_wen,
  input  logic [REG_W-1:0]             disp_rd,
  input  logic [REG_W-1:0]             disp_rs1,
  input  logic [REG_W-1:0]             disp_rs2,
  output logic [NUM_SFU-1:0]           issue_valid,
  input  logic [NUM_SFU-1:0]           issue_ready,
  output logic [NUM_SFU*3*REG_W-1:0]   issue_regs,
  input  logic [NUM_SFU-1:0]           wb_valid,
  output logic [NUM_SFU-1:0]           wb_ready,
  input  logic                         flush
);

  fust_s_t      rows;
  rstat_entry_t rstat [NREGS];

  logic [NUM_SFU-1:0]     blocked;
  logic [NUM_SFU-1:0]     cand;
  logic [NUM_SFU-1:0]     load;
  logic [2**FU_S_W-1:0]   free;
  fu_sbits_t              g;
  logic                   g_any;
  logic                   clr;
  logic                   hit1, hit2, waw, fire;
  rstat_entry_t           s1, s2, sd;
  fust_s_row_t            load_row;

  always_comb begin
    blocked = '0;
    cand    = '0;
    for (int f = 0; f < NUM_SFU; f++) begin
      for (int j = 0; j < NUM_SFU; j++) begin
        if (j != f && rows[j].state == WAIT &&
            rows[f].wen && rows[f].rd != '0 &&
            ((rows[j].rs1 == rows[f].rd && rows[j].rdy1) ||
             (rows[j].rs2 == rows[f].rd && rows[j].rdy2)))
          blocked[f] = 1'b1;
      end
      cand[f] = wb_valid[f] && rows[f].state == EXEC && !blocked[f];
    end
    g = '0;
    for (int f = NUM_SFU - 1; f >= 0; f--)
      if (cand[f]) g = fu_sbits_t'(f);
    g_any    = (|cand) && !flush;
    wb_ready = '0;
    if (g_any) wb_ready[g] = 1'b1;
    clr = g_any && rows[g].wen && rows[g].rd != '0 &&
          rstat[rows[g].rd].valid && rstat[rows[g].rd].tag == g;
  end

  always_comb begin
    s1   = rstat[disp_rs1];
    s2   = rstat[disp_rs2];
    sd   = rstat[disp_rd];
    // a valid entry tagged g can only name rd of row g
    hit1 = g_any && s1.valid && s1.tag == g && disp_rs1 != '0;
    hit2 = g_any && s2.valid && s2.tag == g && disp_rs2 != '0;
    free = '0;
    for (int f = 0; f < NUM_SFU; f++) begin
`ifdef FUST_BYPASS_EN
      free[f] = rows[f].state == IDLE || wb_ready[f];
`else
      free[f] = rows[f].state == IDLE;
`endif
    end
    waw = disp_wen && disp_rd != '0 && sd.valid;
`ifdef FUST_BYPASS_EN
    if (clr && rows[g].rd == disp_rd) waw = 1'b0;
    disp_ready = fu_legal(disp_fu) && free[disp_fu] && !waw;
`else
    disp_ready = fu_legal(disp_fu) && free[disp_fu] && !waw &&
                 !hit1 && !hit2;
`endif
    fire = disp_valid && disp_ready && !flush;
    load_row       = '0;
    load_row.state = WAIT;
    load_row.wen   = disp_wen;
    load_row.rd    = disp_rd;
    load_row.rs1   = disp_rs1;
    load_row.rs2   = disp_rs2;
    load_row.t1    = s1.tag;
    load_row.t2    = s2.tag;
    load_row.rdy1  = !s1.valid || disp_rs1 == '0 || hit1;
    load_row.rdy2  = !s2.valid || disp_rs2 == '0 || hit2;
    for (int f = 0; f < NUM_SFU; f++)
      load[f] = fire && disp_fu == fu_sbits_t'(f);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rstat[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) rstat[i] <= '0;
    end else begin
      if (clr) rstat[rows[g].rd].valid <= 1'b0;
      if (fire && disp_wen && disp_rd != '0)
        rstat[disp_rd] <= '{valid: 1'b1, tag: disp_fu};
    end
  end

  for (genvar f = 0; f < NUM_SFU; f++) begin : g_row
    scalar_fust_scheduler_row u_row (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .load        (load[f]),
      .load_row    (load_row),
      .issue_ready (issue_ready[f]),
      .grant       (wb_ready[f]),
      .wake        (g_any),
      .wake_tag    (g),
      .row         (rows[f]),
      .issue_valid (issue_valid[f])
    );
    assign issue_regs[f*3*REG_W +: 3*REG_W] =
      {rows[f].rd, rows[f].rs1, rows[f].rs2};
  end

endmodule

// File: tb/tb_scalar_fust_scheduler.sv
// Scoreboard bench for scalar_fust_scheduler: queued expected issue
// operands and writeback grants, plus direct status checks.
module tb_scalar_fust_scheduler;
  import scalar_fust_scheduler_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [FU_S_W-1:0]          disp_fu;
  logic                       disp_wen;
  logic [REG_W-1:0]           disp_rd;
  logic [REG_W-1:0]           disp_rs1;
  logic [REG_W-1:0]           disp_rs2;
  logic [NUM_SFU-1:0]         issue_valid;
  logic [NUM_SFU-1:0]         issue_ready;
  logic [NUM_SFU*3*REG_W-1:0] issue_regs;
  logic [NUM_SFU-1:0]         wb_valid;
  logic [NUM_SFU-1:0]         wb_ready;
  logic                       flush;

  int errs   = 0;
  int checks = 0;

  logic [14:0] iq [NUM_SFU][$];
  int          wq [$];

  scalar_fust_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_fu     (disp_fu),
    .disp_wen    (disp_wen),
    .disp_rd     (disp_rd),
    .disp_rs1    (disp_rs1),
    .disp_rs2    (disp_rs2),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_regs  (issue_regs),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int f = 0; f < NUM_SFU; f++) begin
        if (issue_valid[f] && issue_ready[f]) begin
          chk("issue_q", 64'(iq[f].size() != 0), 64'd1);
          if (iq[f].size() != 0)
            chk($sformatf("issue_regs%0d", f),
                64'(issue_regs[f*15 +: 15]), 64'(iq[f].pop_front()));
        end
      end
      if (wb_ready != '0) begin
        chk("wb_q", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0)
          chk("wb_grant", 64'(wb_ready), 64'd1 << wq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic disp(input int fu, input logic wen,
                      input int rd, input int rs1, input int rs2);
    int n;
    disp_valid = 1'b1;
    disp_fu    = FU_S_W'(fu);
    disp_wen   = wen;
    disp_rd    = REG_W'(rd);
    disp_rs1   = REG_W'(rs1);
    disp_rs2   = REG_W'(rs2);
    look();
    n = 0;
    while (!disp_ready && n < 20) begin
      step();
      look();
      n++;
    end
    chk("disp_accept", 64'(disp_ready), 64'd1);
    if (disp_ready)
      iq[fu].push_back({REG_W'(rd), REG_W'(rs1), REG_W'(rs2)});
    step();
    disp_valid = 1'b0;
  endtask

  task automatic issue(input logic [NUM_SFU-1:0] m);
    issue_ready = m;
    look();
    chk("issue_valid", 64'(issue_valid & m), 64'(m));
    step();
    issue_ready = '0;
  endtask

  task automatic wb(input int f);
    wb_valid[f] = 1'b1;
    wq.push_back(f);
    look();
    chk("wb_ready", 64'(wb_ready), 64'd1 << f);
    step();
    wb_valid[f] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_fu = '0;
    disp_wen = 1'b0; disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0;
    issue_ready = '0; wb_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    look();
    chk("rst_iv", 64'(issue_valid), 64'd0);
    chk("rst_wb", 64'(wb_ready), 64'd0);
    chk("rst_regs", 64'(issue_regs), 64'd0);
    chk("rst_dr", 64'(disp_ready), 64'd1);
    disp_fu = 2'd3;
    #1;
    chk("rst_fu3", 64'(disp_ready), 64'd0);
    disp_fu = '0;
    rst = 1'b0;
    step();

    // basic dispatch, issue, writeback
    disp(0, 1'b1, 5, 1, 2);
    look();
    chk("t1_iv", 64'(issue_valid), 64'b001);
    chk("t1_busy", 64'(disp_ready), 64'd0);
    step();
    issue(3'b001);
    look();
    chk("t1_exec", 64'(issue_valid), 64'd0);
    step();
    wb(0);
    look();
    chk("t1_free", 64'(disp_ready), 64'd1);
    step();

    // RAW wakeup
    disp(0, 1'b1, 3, 0, 0);
    issue(3'b001);
    disp(1, 1'b1, 8, 3, 0);
    look();
    chk("t2_wait", 64'(issue_valid), 64'd0);
    step();
    wb(0);
    look();
    chk("t2_wake", 64'(issue_valid), 64'b010);
    step();
    issue(3'b010);
    wb(1);

    // WAW stall
    disp(0, 1'b1, 7, 0, 0);
    issue(3'b001);
    disp_fu = 2'd2; disp_wen = 1'b1; disp_rd = 5'd7;
    disp_rs1 = '0; disp_rs2 = '0; disp_valid = 1'b1;
    look();
    chk("t3_waw0", 64'(disp_ready), 64'd0);
    step();
    look();
    chk("t3_waw1", 64'(disp_ready), 64'd0);
    step();
    disp_valid = 1'b0;
    wb_valid = 3'b001;
    wq.push_back(0);
    look();
    chk("t3_grant", 64'(wb_ready), 64'b001);
`ifdef FUST_BYPASS_EN
    chk("t3_gcyc", 64'(disp_ready), 64'd1);
`else
    chk("t3_gcyc", 64'(disp_ready), 64'd0);
`endif
    step();
    wb_valid = '0;
    look();
    chk("t3_after", 64'(disp_ready), 64'd1);
    step();
    disp(2, 1'b1, 7, 0, 0);
    issue(3'b100);
    wb(2);

    // WAR block
    disp(2, 1'b1, 9, 0, 0);
    issue(3'b100);
    disp(1, 1'b1, 10, 9, 4);
    disp(0, 1'b1, 4, 0, 0);
    issue(3'b001);
    wb_valid = 3'b001;
    look();
    chk("t4_blk0", 64'(wb_ready), 64'd0);
    step();
    look();
    chk("t4_blk1", 64'(wb_ready), 64'd0);
    step();
    wb_valid = 3'b101;
    wq.push_back(2);
    look();
    chk("t4_br", 64'(wb_ready), 64'b100);
    step();
    wb_valid = 3'b001;
    look();
    chk("t4_ldiv", 64'(issue_valid), 64'b010);
    chk("t4_blk2", 64'(wb_ready), 64'd0);
    issue_ready = 3'b010;
    step();
    issue_ready = '0;
    wq.push_back(0);
    look();
    chk("t4_alu", 64'(wb_ready), 64'b001);
    step();
    wb_valid = '0;
    wb(1);

    // priority grant order
    disp(0, 1'b1, 11, 12, 13);
    disp(1, 1'b1, 14, 15, 16);
    disp(2, 1'b1, 17, 18, 19);
    look();
    chk("t5_iv", 64'(issue_valid), 64'b111);
    step();
    issue(3'b111);
    wb_valid = 3'b111;
    for (int k = 0; k < NUM_SFU; k++) begin
      wq.push_back(k);
      look();
      chk("t5_g", 64'(wb_ready), 64'd1 << k);
      step();
      wb_valid[k] = 1'b0;
    end

    // flush
    disp(0, 1'b1, 20, 0, 0);
    issue(3'b001);
    disp(1, 1'b1, 21, 20, 0);
    disp(2, 1'b1, 22, 0, 0);
    wb_valid = 3'b001;
    flush = 1'b1;
    disp_valid = 1'b1; disp_fu = 2'd2; disp_rd = 5'd23;
    look();
    chk("t6_wbf", 64'(wb_ready), 64'd0);
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    iq[1].delete();
    iq[2].delete();
    disp_fu = 2'd0; disp_wen = 1'b1; disp_rd = 5'd20;
    look();
    chk("t6_iv", 64'(issue_valid), 64'd0);
    chk("t6_wbign", 64'(wb_ready), 64'd0);
    chk("t6_rstat", 64'(disp_ready), 64'd1);
    disp_fu = 2'd3;
    #1;
    chk("t6_fu3", 64'(disp_ready), 64'd0);
    step();
    wb_valid = '0;
    disp_valid = 1'b1; disp_fu = 2'd0; disp_wen = 1'b1;
    disp_rd = 5'd25; disp_rs1 = '0; disp_rs2 = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    look();
    chk("t6_drop", 64'(issue_valid), 64'd0);
    chk("t6_drop_rs", 64'(disp_ready), 64'd1);
    step();

    // asynchronous reset mid-operation
    disp(0, 1'b1, 26, 0, 0);
    look();
    chk("t7_iv", 64'(issue_valid), 64'b001);
    rst = 1'b1;
    #1;
    chk("t7_rst", 64'(issue_valid), 64'd0);
    chk("t7_regs", 64'(issue_regs), 64'd0);
    iq[0].delete();
    step();
    rst = 1'b0;
    step();

    chk("iq_left", 64'(iq[0].size() + iq[1].size() + iq[2].size()), 64'd0);
    chk("wq_left", 64'(wq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
